tone_volume_ctrl: RTL and testbench

- Parametrised successor to the fixed three-button tone selector.
- Maps N debounced key levels to a note divider, with lowest-index priority and three-octave shifting.
- Adds saturating volume stepping, mute toggle, and a release phase with half amplitude on key-up.
- Sits between the debounce_circuit instances and note_gen; drives note_gen's divider and amplitude inputs.

---
 rtl/tone_volume_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_tone_volume_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_volume_ctrl.sv
// Purpose: turns debounced key/volume/octave/mute levels into note_gen divider and amplitude.
// Latency: one clk from an input change to the registered outputs.
// Backpressure: none; note_gen consumes the outputs continuously, inputs are sampled every cycle.
//
// Ports:
//   clk, rst_n        clock; synchronous reset, asserted when rst_n is HIGH
//   key_in            NUM_KEYS debounced note keys, 1 = pressed, lowest index wins
//   vol_up/vol_down   volume step buttons (levels; a rising level is one press)
//   oct_up/oct_down   octave step buttons (levels; range 0..2)
//   mute_tgl          mute toggle button (level)
//   note_div          divider for note_gen, 0 = silence
//   amp_pos/amp_neg   signed amplitude pair, amp_neg = -amp_pos
//   vol_level, octave current volume step and octave (0 low, 1 middle, 2 high)
//   note_valid        high while a note is playing or releasing
module tone_volume_ctrl #(
    parameter int                        NUM_KEYS    = 3,
    parameter int                        DIV_W       = 22,
    parameter int                        AMP_W       = 16,
    parameter int                        VOL_LEVELS  = 8,
    parameter int                        VOL_DEFAULT = 3,
    parameter logic [NUM_KEYS*DIV_W-1:0] BASE_DIVS   = {22'd303030, 22'd340136, 22'd381679},
    parameter int                        RELEASE_CYC = 5_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_KEYS-1:0]           key_in,
    input  logic                          vol_up,
    input  logic                          vol_down,
    input  logic                          oct_up,
    input  logic                          oct_down,
    input  logic                          mute_tgl,
    output logic [DIV_W-1:0]              note_div,
    output logic signed [AMP_W-1:0]       amp_pos,
    output logic signed [AMP_W-1:0]       amp_neg,
    output logic [$clog2(VOL_LEVELS)-1:0] vol_level,
    output logic [1:0]                    octave,
    output logic                          note_valid
);

    localparam int VOL_W    = $clog2(VOL_LEVELS);
    localparam int SEL_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int REL_W    = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam int REL_LAST = (RELEASE_CYC > 0) ? RELEASE_CYC - 1 : 0;
    localparam int AMP_STEP = ((2 ** (AMP_W - 1)) - 1) / VOL_LEVELS;

    localparam logic [VOL_W-1:0] VOL_MAX = VOL_W'(VOL_LEVELS - 1);
    localparam logic [VOL_W-1:0] VOL_RST = VOL_W'(VOL_DEFAULT);
    localparam logic [1:0]       OCT_MAX = 2'd2;

    // Control button bit order inside the edge detector.
    localparam int B_VU = 0;
    localparam int B_VD = 1;
    localparam int B_OU = 2;
    localparam int B_OD = 3;
    localparam int B_MT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_REL  = 2'd2
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [REL_W-1:0]   rel_cnt;
    logic               mute;
    logic [4:0]         ctl_prev;

    logic [4:0]         ctl_now;
    logic [4:0]         ctl_evt;
    logic [VOL_W-1:0]   vol_nxt;
    logic [1:0]         oct_nxt;
    logic               mute_nxt;
    logic               any_key;
    logic [SEL_W-1:0]   sel_now;
    logic [DIV_W-1:0]   base_now;
    logic [DIV_W-1:0]   base_held;
    logic [DIV_W-1:0]   div_now;
    logic [DIV_W-1:0]   div_held;
    logic [AMP_W-1:0]   amp_full;
    logic [AMP_W-1:0]   amp_play;
    logic [AMP_W-1:0]   amp_rel;

    // ------------------------------------------------------------------
    // Button edge events: one event per rising level.
    // ------------------------------------------------------------------
    assign ctl_now = {mute_tgl, oct_down, oct_up, vol_down, vol_up};
    assign ctl_evt = ctl_now & ~ctl_prev;

    // Saturating volume/octave steps; opposing events in the same cycle cancel.
    always_comb begin
        vol_nxt = vol_level;
        if (ctl_evt[B_VU] && !ctl_evt[B_VD] && (vol_level != VOL_MAX)) begin
            vol_nxt = vol_level + VOL_W'(1);
        end else if (ctl_evt[B_VD] && !ctl_evt[B_VU] && (vol_level != '0)) begin
            vol_nxt = vol_level - VOL_W'(1);
        end
    end

    always_comb begin
        oct_nxt = octave;
        if (ctl_evt[B_OU] && !ctl_evt[B_OD] && (octave != OCT_MAX)) begin
            oct_nxt = octave + 2'd1;
        end else if (ctl_evt[B_OD] && !ctl_evt[B_OU] && (octave != 2'd0)) begin
            oct_nxt = octave - 2'd1;
        end
    end

    assign mute_nxt = mute ^ ctl_evt[B_MT];

    // ------------------------------------------------------------------
    // Key priority: scanning downwards leaves the lowest pressed index.
    // ------------------------------------------------------------------
    assign any_key = |key_in;

    always_comb begin
        sel_now = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_in[i]) begin
                sel_now = SEL_W'(i);
            end
        end
    end

    // Base divider for the freshly selected key and for the latched key.
    always_comb begin
        base_now  = '0;
        base_held = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (sel_now == SEL_W'(i)) begin
                base_now = BASE_DIVS[i*DIV_W +: DIV_W];
            end
            if (sel_q == SEL_W'(i)) begin
                base_held = BASE_DIVS[i*DIV_W +: DIV_W];
            end
        end
    end

    // Lower octave doubles the period, higher octave halves it.
    function automatic logic [DIV_W-1:0] oct_div(input logic [DIV_W-1:0] base,
                                                 input logic [1:0]       oct);
        case (oct)
            2'd0:    return base << 1;
            2'd2:    return base >> 1;
            default: return base;
        endcase
    endfunction

    // Outputs are built from the post-edge octave/volume/mute so a button
    // press shows up on the same edge that registers it.
    assign div_now  = oct_div(base_now, oct_nxt);
    assign div_held = oct_div(base_held, oct_nxt);

    assign amp_full = AMP_W'(AMP_STEP * (int'(vol_nxt) + 1));
    assign amp_play = mute_nxt ? '0 : amp_full;
    assign amp_rel  = mute_nxt ? '0 : (amp_full >> 1);

    // ------------------------------------------------------------------
    // Control registers, state machine and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            // Edge detector loads the live levels so a held button is not an event.
            ctl_prev   <= ctl_now;
            vol_level  <= VOL_RST;
            octave     <= 2'd1;
            mute       <= 1'b0;
            state      <= S_IDLE;
            sel_q      <= '0;
            rel_cnt    <= '0;
            note_div   <= '0;
            amp_pos    <= '0;
            amp_neg    <= '0;
            note_valid <= 1'b0;
        end else begin
            ctl_prev  <= ctl_now;
            vol_level <= vol_nxt;
            octave    <= oct_nxt;
            mute      <= mute_nxt;

            // Silence unless the next state says otherwise.
            note_div   <= '0;
            amp_pos    <= '0;
            amp_neg    <= '0;
            note_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_key) begin
                        state      <= S_PLAY;
                        sel_q      <= sel_now;
                        note_div   <= div_now;
                        amp_pos    <= amp_play;
                        amp_neg    <= -amp_play;
                        note_valid <= 1'b1;
                    end
                end

                S_PLAY: begin
                    if (any_key) begin
                        sel_q      <= sel_now;
                        note_div   <= div_now;
                        amp_pos    <= amp_play;
                        amp_neg    <= -amp_play;
                        note_valid <= 1'b1;
                    end else if (RELEASE_CYC == 0) begin
                        state <= S_IDLE;
                    end else begin
                        // Key-up: keep sounding the last key at half amplitude.
                        state      <= S_REL;
                        rel_cnt    <= '0;
                        note_div   <= div_held;
                        amp_pos    <= amp_rel;
                        amp_neg    <= -amp_rel;
                        note_valid <= 1'b1;
                    end
                end

                S_REL: begin
                    if (any_key) begin
                        state      <= S_PLAY;
                        sel_q      <= sel_now;
                        note_div   <= div_now;
                        amp_pos    <= amp_play;
                        amp_neg    <= -amp_play;
                        note_valid <= 1'b1;
                    end else if (rel_cnt == REL_W'(REL_LAST)) begin
                        state   <= S_IDLE;
                        rel_cnt <= '0;
                    end else begin
                        rel_cnt    <= rel_cnt + REL_W'(1);
                        note_div   <= div_held;
                        amp_pos    <= amp_rel;
                        amp_neg    <= -amp_rel;
                        note_valid <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_volume_ctrl.sv
`timescale 1ns/1ps
module tb_tone_volume_ctrl;

    localparam int REL = 4;
    localparam logic [4:0] P_VU = 5'b00001;
    localparam logic [4:0] P_VD = 5'b00010;
    localparam logic [4:0] P_OU = 5'b00100;
    localparam logic [4:0] P_OD = 5'b01000;
    localparam logic [4:0] P_MT = 5'b10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [2:0]         key_in;
    logic               vol_up, vol_down, oct_up, oct_down, mute_tgl;
    logic [21:0]        note_div;
    logic signed [15:0] amp_pos, amp_neg;
    logic [2:0]         vol_level;
    logic [1:0]         octave;
    logic               note_valid;

    tone_volume_ctrl #(.RELEASE_CYC(REL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .vol_up     (vol_up),
        .vol_down   (vol_down),
        .oct_up     (oct_up),
        .oct_down   (oct_down),
        .mute_tgl   (mute_tgl),
        .note_div   (note_div),
        .amp_pos    (amp_pos),
        .amp_neg    (amp_neg),
        .vol_level  (vol_level),
        .octave     (octave),
        .note_valid (note_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: phase 0 silent, 1 playing, 2 releasing.
    int         base_tab[3] = '{381679, 340136, 303030};
    int         m_vol, m_oct, m_mute, m_phase, m_key, m_rel_left;
    logic [4:0] m_prev;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int e_div();
        if (m_phase == 0) return 0;
        case (m_oct)
            0:       return base_tab[m_key] * 2;
            1:       return base_tab[m_key];
            default: return base_tab[m_key] / 2;
        endcase
    endfunction

    function automatic int e_amp();
        int full;
        full = (32767 / 8) * (m_vol + 1);
        if (m_phase == 0 || m_mute != 0) return 0;
        return (m_phase == 2) ? full / 2 : full;
    endfunction

    // Advance one clock; the model consumes the same inputs the DUT samples.
    task automatic tick();
        logic [4:0] now, ev;
        @(posedge clk);
        now = {mute_tgl, oct_down, oct_up, vol_down, vol_up};
        if (rst_n) begin
            m_vol = 3; m_oct = 1; m_mute = 0; m_phase = 0; m_prev = now;
        end else begin
            ev     = now & ~m_prev;
            m_prev = now;
            m_vol  = clamp(m_vol + int'(ev[0]) - int'(ev[1]), 0, 7);
            m_oct  = clamp(m_oct + int'(ev[2]) - int'(ev[3]), 0, 2);
            m_mute = m_mute ^ int'(ev[4]);
            if (key_in != 3'b000) begin
                m_phase = 1;
                for (int i = 2; i >= 0; i--) if (key_in[i]) m_key = i;
            end else if (m_phase == 1) begin
                m_phase    = 2;
                m_rel_left = REL;
            end else if (m_phase == 2) begin
                m_rel_left--;
                if (m_rel_left == 0) m_phase = 0;
            end
        end
        #1;
    endtask

    task automatic set_ctl(input logic [4:0] m);
        {mute_tgl, oct_down, oct_up, vol_down, vol_up} = m;
    endtask

    task automatic pulse(input logic [4:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            set_ctl(m);  tick();
            set_ctl('0); tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1; tick();
        rst_n = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; key_in = '0; set_ctl('0);
        tick(); tick();
        n_cmp++; if (note_div !== 22'd0) begin n_bad++; $display("FAIL reset_div got %0d want 0", note_div); end
        n_cmp++; if (amp_pos !== 16'sd0 || amp_neg !== 16'sd0) begin n_bad++; $display("FAIL reset_amp got %0d/%0d want 0/0", amp_pos, amp_neg); end
        n_cmp++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", note_valid); end
        n_cmp++; if (vol_level !== 3'd3 || octave !== 2'd1) begin n_bad++; $display("FAIL reset_vol_oct got %0d/%0d want 3/1", vol_level, octave); end
        rst_n = 1'b0; tick();
    endtask

    task automatic test_key_octave();
        key_in = 3'b001; tick();
        n_cmp++; if (note_div !== 22'd381679) begin n_bad++; $display("FAIL key0_div got %0d want 381679", note_div); end
        n_cmp++; if (amp_pos !== 16'sd16380 || amp_neg !== -16'sd16380) begin n_bad++; $display("FAIL key0_amp got %0d/%0d want 16380/-16380", amp_pos, amp_neg); end
        n_cmp++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL key0_valid got %b want 1", note_valid); end
        key_in = 3'b110; tick();
        n_cmp++; if (note_div !== 22'd340136) begin n_bad++; $display("FAIL key_priority got %0d want 340136", note_div); end
        set_ctl(P_OU); tick();
        n_cmp++; if (note_div !== 22'd170068) begin n_bad++; $display("FAIL oct_up_div got %0d want 170068", note_div); end
        set_ctl('0); tick();
        pulse(P_OU, 2);
        n_cmp++; if (octave !== 2'd2 || note_div !== 22'd170068) begin n_bad++; $display("FAIL oct_sat_hi got %0d/%0d want 2/170068", octave, note_div); end
        pulse(P_OD, 3);
        n_cmp++; if (octave !== 2'd0 || note_div !== 22'd680272) begin n_bad++; $display("FAIL oct_sat_lo got %0d/%0d want 0/680272", octave, note_div); end
        key_in = '0; repeat (REL + 2) tick();
        n_cmp++; if (note_valid !== 1'b0 || note_div !== 22'd0) begin n_bad++; $display("FAIL key_off_idle got %b/%0d want 0/0", note_valid, note_div); end
    endtask

    task automatic test_volume();
        do_reset();
        pulse(P_VU, 9);
        n_cmp++; if (vol_level !== 3'd7) begin n_bad++; $display("FAIL vol_sat_hi got %0d want 7", vol_level); end
        key_in = 3'b001; tick();
        n_cmp++; if (amp_pos !== 16'sd32760) begin n_bad++; $display("FAIL vol_max_amp got %0d want 32760", amp_pos); end
        pulse(P_VU | P_VD, 1);
        n_cmp++; if (vol_level !== 3'd7) begin n_bad++; $display("FAIL vol_both got %0d want 7", vol_level); end
        pulse(P_VD, 10);
        n_cmp++; if (vol_level !== 3'd0 || amp_pos !== 16'sd4095) begin n_bad++; $display("FAIL vol_sat_lo got %0d/%0d want 0/4095", vol_level, amp_pos); end
        key_in = '0; repeat (REL + 2) tick();
    endtask

    task automatic test_release();
        do_reset();
        key_in = 3'b001; tick();
        key_in = '0;
        for (int i = 0; i < REL; i++) begin
            tick();
            n_cmp++;
            if (note_div !== 22'd381679 || amp_pos !== 16'sd8190 || note_valid !== 1'b1) begin
                n_bad++; $display("FAIL rel_cyc%0d got %0d/%0d/%b want 381679/8190/1", i, note_div, amp_pos, note_valid);
            end
        end
        tick();
        n_cmp++; if (note_div !== 22'd0 || amp_pos !== 16'sd0 || note_valid !== 1'b0) begin n_bad++; $display("FAIL rel_end got %0d/%0d/%b want 0/0/0", note_div, amp_pos, note_valid); end
        key_in = 3'b001; tick();
        key_in = '0; tick(); tick();
        key_in = 3'b100; tick();
        n_cmp++; if (note_div !== 22'd303030 || amp_pos !== 16'sd16380 || note_valid !== 1'b1) begin n_bad++; $display("FAIL rel_repress got %0d/%0d/%b want 303030/16380/1", note_div, amp_pos, note_valid); end
        key_in = '0; repeat (REL + 2) tick();
    endtask

    task automatic test_mute();
        key_in = 3'b001; tick();
        set_ctl(P_MT); tick();
        n_cmp++; if (amp_pos !== 16'sd0 || amp_neg !== 16'sd0) begin n_bad++; $display("FAIL mute_amp got %0d/%0d want 0/0", amp_pos, amp_neg); end
        n_cmp++; if (note_div !== 22'd381679 || note_valid !== 1'b1) begin n_bad++; $display("FAIL mute_div got %0d/%b want 381679/1", note_div, note_valid); end
        set_ctl('0); tick();
        pulse(P_MT, 1);
        n_cmp++; if (amp_pos !== 16'sd16380 || amp_neg !== -16'sd16380) begin n_bad++; $display("FAIL unmute_amp got %0d/%0d want 16380/-16380", amp_pos, amp_neg); end
        key_in = '0; repeat (REL + 2) tick();
    endtask

    task automatic test_reset_hold();
        rst_n = 1'b1; vol_up = 1'b1; tick(); tick();
        rst_n = 1'b0; tick(); tick();
        n_cmp++; if (vol_level !== 3'd3) begin n_bad++; $display("FAIL held_vol_up got %0d want 3", vol_level); end
        vol_up = 1'b0; tick();
        key_in = 3'b001; tick();
        pulse(P_OU, 1);
        key_in = '0; tick();
        n_cmp++; if (note_valid !== 1'b1 || note_div !== 22'd190839) begin n_bad++; $display("FAIL pre_rst_rel got %b/%0d want 1/190839", note_valid, note_div); end
        rst_n = 1'b1; tick();
        n_cmp++; if (note_div !== 22'd0 || amp_pos !== 16'sd0 || note_valid !== 1'b0 || octave !== 2'd1) begin
            n_bad++; $display("FAIL rst_mid_rel got %0d/%0d/%b/%0d want 0/0/0/1", note_div, amp_pos, note_valid, octave);
        end
        rst_n = 1'b0; tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) key_in = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            for (int b = 0; b < 5; b++) begin
                case (b)
                    0: vol_up   = ($urandom_range(0, 3) == 0);
                    1: vol_down = ($urandom_range(0, 3) == 0);
                    2: oct_up   = ($urandom_range(0, 5) == 0);
                    3: oct_down = ($urandom_range(0, 5) == 0);
                    default: mute_tgl = ($urandom_range(0, 9) == 0);
                endcase
            end
            tick();
            n_cmp++;
            if (int'(note_div) !== e_div() || int'(amp_pos) !== e_amp() || int'(amp_neg) !== -e_amp()
                || int'(note_valid) !== int'(m_phase != 0) || int'(vol_level) !== m_vol || int'(octave) !== m_oct) begin
                n_bad++;
                $display("FAIL rand_c%0d got div=%0d amp=%0d/%0d v=%b vol=%0d oct=%0d want div=%0d amp=%0d v=%0d vol=%0d oct=%0d",
                         c, note_div, amp_pos, amp_neg, note_valid, vol_level, octave,
                         e_div(), e_amp(), int'(m_phase != 0), m_vol, m_oct);
            end
        end
        rst_n = 1'b0; key_in = '0; set_ctl('0);
    endtask

    initial begin
        rst_n = 1'b1; key_in = '0; set_ctl('0);
        test_reset();
        test_key_octave();
        test_volume();
        test_release();
        test_mute();
        test_reset_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
